// File: rtl/system_pio_key_in.sv
// rtl/system_pio_key_in.sv - Avalon-MM input PIO with edge capture and maskable irq
//
// Purpose:
//   Samples external pins (keys/switches) into the clk domain and exposes their level.
//   Selected edges are latched into a sticky EDGECAPTURE register.
//   irq is a registered level: the OR of EDGECAPTURE & IRQMASK.
//
// Register map:
//   0 DATA         read-only synchronized pin level
//   1 DIRECTION    reads 0, writes ignored
//   2 IRQMASK      read/write
//   3 EDGECAPTURE  read; write clears
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous active-high reset
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, only [WIDTH-1:0] used
//   readdata    combinational read data, zero-extended, 0 when not selected
//   in_port     asynchronous external pins
//   irq         registered active-high level interrupt
//
// Optional feature:
//   PIO_KEY_BIT_CLEAR_EN
//     Defined: a write to EDGECAPTURE clears only the bits set in writedata
//       (write-1-to-clear).
//     Undefined: any write to EDGECAPTURE clears every bit.

module system_pio_key_in #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int CNT_W    = $clog2(WARM_MAX + 1);
  localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(WARM_MAX);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [CNT_W-1:0] warm_q, warm_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise, fall, edge_sel, edge_hit, clr;
  logic             wr_en;
  logic             unused_wdata;

  assign sync         = sync_q[SYNC_STAGES-1];
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync;
  end

  always_comb begin
    rise = sync & ~prev_q;
    fall = ~sync & prev_q;
    if (EDGE_TYPE == 0) begin
      edge_sel = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_sel = fall;
    end else begin
      edge_sel = rise | fall;
    end
    // Until the synchronizer and prev have filled with real pin values, the
    // prev=0 reset state would look like a rising edge on every high pin.
    edge_hit = (warm_q == WARM_DONE) ? edge_sel : '0;
  end

  always_comb begin
    warm_d = (warm_q == WARM_DONE) ? warm_q : warm_q + CNT_W'(1);
    irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
`ifdef PIO_KEY_BIT_CLEAR_EN
    clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
`else
    clr = (wr_en && address == 2'd3) ? '1 : '0;
`endif
    // OR-ing the new edges in after the clear means a capture is never lost
    // to a clear arriving in the same cycle.
    edgecap_d = (edgecap_q & ~clr) | edge_hit;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata = 32'(sync);
        2'd2:    readdata = 32'(irqmask_q);
        2'd3:    readdata = 32'(edgecap_q);
        default: readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      warm_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      warm_q    <= warm_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_system_pio_key_in.sv
// tb/tb_system_pio_key_in.sv - scoreboard bench for system_pio_key_in

module tb_system_pio_key_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  string       sb_name[$];
  logic [31:0] sb_data[$];
  int          sb_irq[$];

  always #5 clk = ~clk;

  system_pio_key_in #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // exp_irq < 0 means irq is not checked on this read
  task automatic rd(input logic [1:0] a, input logic [31:0] exp_data, input int exp_irq, input string nm);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    sb_name.push_back(nm);
    sb_data.push_back(exp_data);
    sb_irq.push_back(exp_irq);
    tick();
    chipselect = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb_data.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain: pending=%0d required=0", sb_data.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (chipselect && write_n) begin
      if (sb_data.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: addr=%0d no expectation queued", address);
      end else begin
        string       nm;
        logic [31:0] ed;
        int          ei;
        nm = sb_name.pop_front();
        ed = sb_data.pop_front();
        ei = sb_irq.pop_front();
        checks++;
        if (readdata !== ed) begin
          failures++;
          $display("FAIL %s: readdata=0x%08h required=0x%08h", nm, readdata, ed);
        end
        if (ei >= 0) begin
          checks++;
          if (irq !== ei[0]) begin
            failures++;
            $display("FAIL %s_irq: irq=%0b required=%0b", nm, irq, ei[0]);
          end
        end
      end
    end else if (!chipselect) begin
      checks++;
      if (readdata !== 32'h0) begin
        failures++;
        $display("FAIL idle_readdata: readdata=0x%08h required=0x00000000", readdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'hF;

    // 1: pins high through reset, warm-up must hide them
    idle(3);
    reset = 1'b0;
    idle(10);
    rd(2'd0, 32'h0000_000F, 0, "t1_data");
    rd(2'd3, 32'h0000_0000, 0, "t1_edgecap");
    rd(2'd2, 32'h0000_0000, 0, "t1_irqmask");

    // 2: falling edge on bit 0, exact latency
    wr(2'd2, 32'h1);
    in_port = 4'hE;
    idle(1);
    rd(2'd0, 32'h0000_000F, 0, "t2_data_before");
    rd(2'd3, 32'h0, 0, "t2_cap_early");
    rd(2'd3, 32'h1, 0, "t2_cap_set");
    rd(2'd3, 32'h1, 1, "t2_irq_set");
    rd(2'd0, 32'h0000_000E, 1, "t2_data_after");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, 1, "t2_cap_clr");
    rd(2'd3, 32'h0, 0, "t2_irq_clr");

    // 3: masked capture, then unmask
    wr(2'd2, 32'h0);
    in_port = 4'hA;
    idle(3);
    rd(2'd3, 32'h4, 0, "t3_cap_masked");
    rd(2'd3, 32'h4, 0, "t3_irq_masked");
    wr(2'd2, 32'h4);
    rd(2'd3, 32'h4, 0, "t3_unmask_lat");
    rd(2'd3, 32'h4, 1, "t3_unmask_irq");
    rd(2'd2, 32'h4, 1, "t3_mask_rd");

    // 4: capture on bit 1 lands on the same edge as a clear
    in_port = 4'h8;
    idle(2);
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h2, 1, "t4_set_over_clr");
    rd(2'd3, 32'h2, 0, "t4_irq_drop");

    // 5: partial clear
    in_port = 4'hF;
    idle(4);
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, -1, "t5_cleared");
    in_port = 4'h3;
    idle(4);
    rd(2'd3, 32'hC, -1, "t5_cap_c");
    wr(2'd3, 32'h4);
`ifdef PIO_KEY_BIT_CLEAR_EN
    rd(2'd3, 32'h8, -1, "t5_w1c");
`else
    rd(2'd3, 32'h0, -1, "t5_clr_all");
`endif

    // 6: reset while irq pending
    wr(2'd2, 32'h3);
    wr(2'd3, 32'hF);
    in_port = 4'h0;
    idle(4);
    rd(2'd3, 32'h3, 1, "t6_cap_pre");
    rd(2'd2, 32'h3, 1, "t6_mask_pre");
    rd(2'd1, 32'h0, 1, "t6_dir");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(2'd3, 32'h0, 0, "t6_cap_rst");
    rd(2'd2, 32'h0, 0, "t6_mask_rst");
    rd(2'd0, 32'h0, 0, "t6_data_rst");

    // upper bits and ignored writes
    wr(2'd2, 32'hFFFF_FFF5);
    rd(2'd2, 32'h5, -1, "hi_bits_mask");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0, -1, "dir_write_ignored");
    in_port = 4'h5;
    idle(3);
    wr(2'd0, 32'h0);
    rd(2'd0, 32'h5, -1, "data_write_ignored");

    idle(2);
    done = 1'b1;
  end

endmodule
